// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: target-select codes,
// FSM state encoding and requester identifiers.
package sram_arb_pkg;

    // Target select codes carried on x_SEL
    localparam logic [1:0] SEL_SRAM   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_PTR_LO = 2'd2;
    localparam logic [1:0] SEL_PTR_HI = 2'd3;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SETUP   = ST_SETUP,
        STROBE  = ST_STROBE,
        RELEASE = ST_RELEASE,
        DONE    = ST_DONE
    } arb_state_t;

    // Requester identifiers (also the encoding of last_grant / cur)
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for the SRAM port arbiter.
//   A_* / B_* : four-phase request/acknowledge ports of requesters A and B
//               (REQ, WR, SEL, WDATA in; RDATA, ACK out of the arbiter).
//   RAM_*     : asynchronous SRAM pins (address, data out + driver enable,
//               data in, active-low output and write enables).
// slave  : arbiter side.   master : requesters + SRAM side.
interface sram_port_arbiter_if #(
    parameter int AW = 16
);
    logic          A_REQ;
    logic          A_WR;
    logic [1:0]    A_SEL;
    logic [7:0]    A_WDATA;
    logic [7:0]    A_RDATA;
    logic          A_ACK;

    logic          B_REQ;
    logic          B_WR;
    logic [1:0]    B_SEL;
    logic [7:0]    B_WDATA;
    logic [7:0]    B_RDATA;
    logic          B_ACK;

    logic [AW-1:0] RAM_A;
    logic [7:0]    RAM_DO;
    logic          RAM_DOE;
    logic [7:0]    RAM_DI;
    logic          RAM_OE_n;
    logic          RAM_WE_n;

    modport slave (
        input  A_REQ, A_WR, A_SEL, A_WDATA,
        output A_RDATA, A_ACK,
        input  B_REQ, B_WR, B_SEL, B_WDATA,
        output B_RDATA, B_ACK,
        output RAM_A, RAM_DO, RAM_DOE, RAM_OE_n, RAM_WE_n,
        input  RAM_DI
    );

    modport master (
        output A_REQ, A_WR, A_SEL, A_WDATA,
        input  A_RDATA, A_ACK,
        output B_REQ, B_WR, B_SEL, B_WDATA,
        input  B_RDATA, B_ACK,
        input  RAM_A, RAM_DO, RAM_DOE, RAM_OE_n, RAM_WE_n,
        output RAM_DI
    );

endinterface

// File: rtl/sram_port_arbiter_req_sync2.sv
// Two-flop synchroniser for an asynchronous request level.
//   CLK   : destination clock
//   RST_n : synchronous active-low reset, clears both flops
//   d     : asynchronous input level
//   q     : synchronised level, two CLK edges behind d
module req_sync2 (
    input  logic CLK,
    input  logic RST_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single asynchronous SRAM. Each requester
// owns an auto-incrementing address pointer; contending requests are served
// round-robin and every SRAM access is sequenced SETUP -> STROBE -> RELEASE.
//   CLK   : system clock
//   RST_n : synchronous active-low reset
//   bus   : slave side of sram_port_arbiter_if (A/B handshakes, SRAM pins)
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW            = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    sram_port_arbiter_if.slave   bus
);

    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic             req_a_s, req_b_s;
    arb_state_t       state;
    logic [AW-1:0]    ptr_a, ptr_b;
    logic             last_grant, cur;
    logic [1:0]       op_sel;
    logic             op_wr;
    logic [7:0]       op_wdata;
    logic [CNT_W-1:0] cnt;

    logic             a_ack, b_ack;
    logic [7:0]       a_rdata, b_rdata;
    logic [AW-1:0]    ram_a;
    logic [7:0]       ram_do;
    logic             ram_doe, ram_oe_n, ram_we_n;

    logic             pend_a, pend_b, pend_other, grant_side;
    logic [1:0]       gnt_sel;
    logic             gnt_wr;
    logic [7:0]       gnt_wdata;
    logic [AW-1:0]    ptr_cur;
    logic [7:0]       hi_byte;

    req_sync2 u_sync_a (.CLK(CLK), .RST_n(RST_n), .d(bus.A_REQ), .q(req_a_s));
    req_sync2 u_sync_b (.CLK(CLK), .RST_n(RST_n), .d(bus.B_REQ), .q(req_b_s));

    // A side whose ACK is still up has been served and is not pending again
    // until its REQ has dropped and the ACK has cleared.
    assign pend_a = req_a_s & ~a_ack;
    assign pend_b = req_b_s & ~b_ack;

    // On a tie the side that did not win last time gets the grant.
    assign grant_side = (pend_a & pend_b) ? ~last_grant : (pend_b ? REQ_B : REQ_A);
    assign gnt_sel    = (grant_side == REQ_B) ? bus.B_SEL   : bus.A_SEL;
    assign gnt_wr     = (grant_side == REQ_B) ? bus.B_WR    : bus.A_WR;
    assign gnt_wdata  = (grant_side == REQ_B) ? bus.B_WDATA : bus.A_WDATA;

    assign ptr_cur    = (cur == REQ_B) ? ptr_b : ptr_a;
    assign pend_other = (cur == REQ_B) ? pend_a : pend_b;

    always_comb begin
        hi_byte          = 8'h00;
        hi_byte[AW-9:0]  = ptr_cur[AW-1:8];
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state      <= IDLE;
            ptr_a      <= '0;
            ptr_b      <= '0;
            last_grant <= REQ_B;
            cur        <= REQ_A;
            cnt        <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= 8'h00;
            b_rdata    <= 8'h00;
            ram_a      <= '0;
            ram_do     <= 8'h00;
            ram_doe    <= 1'b0;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
        end else begin
            if (!req_a_s) a_ack <= 1'b0;
            if (!req_b_s) b_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend_a || pend_b) begin
                        last_grant <= grant_side;
                        cur        <= grant_side;
                        op_sel     <= gnt_sel;
                        op_wr      <= gnt_wr;
                        op_wdata   <= gnt_wdata;
                        state      <= (gnt_sel == SEL_SRAM) ? SETUP : DONE;
                    end
                end

                // Address (and write data) settle one cycle before the strobe
                SETUP: begin
                    ram_a <= ptr_cur;
                    if (op_wr) begin
                        ram_do  <= op_wdata;
                        ram_doe <= 1'b1;
                    end else begin
                        ram_oe_n <= 1'b0;
                    end
                    cnt   <= CNT_W'(STROBE_CYCLES - 1);
                    state <= STROBE;
                end

                STROBE: begin
                    if (op_wr) ram_we_n <= 1'b0;
                    if (cnt == '0) begin
                        if (!op_wr) begin
                            if (cur == REQ_B) b_rdata <= bus.RAM_DI;
                            else              a_rdata <= bus.RAM_DI;
                        end
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                RELEASE: begin
                    ram_we_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    if (cur == REQ_B) ptr_b <= ptr_b + PTR_ONE;
                    else              ptr_a <= ptr_a + PTR_ONE;
                    state <= DONE;
                end

                // Data drivers are released one cycle after WE rises
                DONE: begin
                    ram_doe <= 1'b0;
                    case (op_sel)
                        SEL_PTR_LO: begin
                            if (op_wr) begin
                                if (cur == REQ_B) ptr_b[7:0] <= op_wdata;
                                else              ptr_a[7:0] <= op_wdata;
                            end else begin
                                if (cur == REQ_B) b_rdata <= ptr_cur[7:0];
                                else              a_rdata <= ptr_cur[7:0];
                            end
                        end
                        SEL_PTR_HI: begin
                            if (op_wr) begin
                                if (cur == REQ_B) ptr_b[AW-1:8] <= op_wdata[AW-9:0];
                                else              ptr_a[AW-1:8] <= op_wdata[AW-9:0];
                            end else begin
                                if (cur == REQ_B) b_rdata <= hi_byte;
                                else              a_rdata <= hi_byte;
                            end
                        end
                        SEL_STATUS: begin
                            if (!op_wr) begin
                                if (cur == REQ_B) b_rdata <= {6'b0, pend_other, last_grant == REQ_B};
                                else              a_rdata <= {6'b0, pend_other, last_grant == REQ_B};
                            end
                        end
                        default: ;
                    endcase
                    if (cur == REQ_B) b_ack <= 1'b1;
                    else              a_ack <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A_ACK    = a_ack;
    assign bus.B_ACK    = b_ack;
    assign bus.A_RDATA  = a_rdata;
    assign bus.B_RDATA  = b_rdata;
    assign bus.RAM_A    = ram_a;
    assign bus.RAM_DO   = ram_do;
    assign bus.RAM_DOE  = ram_doe;
    assign bus.RAM_OE_n = ram_oe_n;
    assign bus.RAM_WE_n = ram_we_n;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a behavioural model of pointers and
// memory predicts each response and each SRAM write; monitors compare.
module tb_sram_port_arbiter;

    localparam int AW = 16;
    localparam int SC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.AW(AW)) bus ();

    sram_port_arbiter #(.AW(AW), .STROBE_CYCLES(SC)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus.slave)
    );

    // SRAM model: written on the rising edge of WE_n, read while OE_n low
    logic [7:0] sram [0:65535];
    always @(posedge bus.RAM_WE_n) begin
        if (bus.RAM_DOE === 1'b1) sram[bus.RAM_A] = bus.RAM_DO;
    end
    assign bus.RAM_DI = (bus.RAM_OE_n == 1'b0) ? sram[bus.RAM_A] : 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed { logic rd; logic [7:0] data; } rsp_t;
    typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;

    rsp_t          exp_a[$];
    rsp_t          exp_b[$];
    wr_t           wr_q[$];
    logic [AW-1:0] ptr_m [2];
    logic [7:0]    mem_m [0:65535];
    logic          mon_en = 1'b1;
    int            both_viol = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: effect of one operation, in service order
    function automatic void model_push(logic side, logic wr, logic [1:0] sel,
                                       logic [7:0] wdata, logic [7:0] stat);
        rsp_t r;
        int   s = side ? 1 : 0;
        r = '0;
        case (sel)
            2'd0: begin
                if (wr) begin
                    wr_q.push_back({ptr_m[s], wdata});
                    mem_m[ptr_m[s]] = wdata;
                end else begin
                    r = {1'b1, mem_m[ptr_m[s]]};
                end
                ptr_m[s] = ptr_m[s] + 16'd1;
            end
            2'd1: if (!wr) r = {1'b1, stat};
            2'd2: if (wr) ptr_m[s][7:0] = wdata; else r = {1'b1, ptr_m[s][7:0]};
            default: if (wr) ptr_m[s][15:8] = wdata; else r = {1'b1, ptr_m[s][15:8]};
        endcase
        if (side) exp_b.push_back(r);
        else      exp_a.push_back(r);
    endfunction

    // Four-phase handshake on one side; exp_lat > 0 also checks REQ-to-ACK edges
    task automatic drive(input logic side, input logic wr, input logic [1:0] sel,
                         input logic [7:0] wdata, input int exp_lat);
        int   cnt = 0;
        logic got = 1'b0;
        @(posedge clk); #1;
        if (side) begin
            bus.B_WR = wr; bus.B_SEL = sel; bus.B_WDATA = wdata; bus.B_REQ = 1'b1;
        end else begin
            bus.A_WR = wr; bus.A_SEL = sel; bus.A_WDATA = wdata; bus.A_REQ = 1'b1;
        end
        while (!got && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            got = side ? bus.B_ACK : bus.A_ACK;
        end
        if (!got) check(side ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
        else if (exp_lat > 0) check(side ? "b_latency" : "a_latency", cnt, exp_lat);
        if (side) bus.B_REQ = 1'b0; else bus.A_REQ = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check(side ? "b_ack_release" : "a_ack_release", side ? bus.B_ACK : bus.A_ACK, 0);
    endtask

    task automatic op(input logic side, input logic wr, input logic [1:0] sel,
                      input logic [7:0] wdata, input logic [7:0] stat, input int lat);
        model_push(side, wr, sel, wdata, stat);
        drive(side, wr, sel, wdata, lat);
    endtask

    // Response monitor
    logic a_prev = 1'b0, b_prev = 1'b0;
    always @(negedge clk) begin
        rsp_t r;
        if (bus.A_ACK === 1'b1 && !a_prev) begin
            if (exp_a.size() == 0) check("a_unexpected_ack", 1, 0);
            else begin
                r = exp_a.pop_front();
                if (r.rd) check("a_rdata", bus.A_RDATA, r.data);
            end
        end
        if (bus.B_ACK === 1'b1 && !b_prev) begin
            if (exp_b.size() == 0) check("b_unexpected_ack", 1, 0);
            else begin
                r = exp_b.pop_front();
                if (r.rd) check("b_rdata", bus.B_RDATA, r.data);
            end
        end
        a_prev = (bus.A_ACK === 1'b1);
        b_prev = (bus.B_ACK === 1'b1);
    end

    // SRAM write-strobe monitor
    int            wcnt = 0;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_data;
    logic          w_doe_ok;
    always @(negedge clk) begin
        wr_t w;
        if (bus.RAM_WE_n === 1'b0 && bus.A_ACK === 1'b1 && bus.B_ACK === 1'b1)
            both_viol++;
        if (!mon_en) begin
            wcnt = 0;
        end else if (bus.RAM_WE_n === 1'b0) begin
            if (wcnt == 0) begin
                w_addr   = bus.RAM_A;
                w_data   = bus.RAM_DO;
                w_doe_ok = 1'b1;
            end
            if (bus.RAM_DOE !== 1'b1) w_doe_ok = 1'b0;
            wcnt++;
        end else if (wcnt > 0) begin
            if (wr_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", w_addr, w.addr);
                check("wr_data", w_data, w.data);
            end
            check("we_width", wcnt, SC);
            check("doe_during_we", w_doe_ok, 1);
            wcnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       s;
        int         k;
        logic [7:0] d;

        for (int i = 0; i < 65536; i++) begin
            sram[i]  = 8'h00;
            mem_m[i] = 8'h00;
        end
        ptr_m[0] = '0;
        ptr_m[1] = '0;
        bus.A_REQ = 0; bus.A_WR = 0; bus.A_SEL = 0; bus.A_WDATA = 0;
        bus.B_REQ = 0; bus.B_WR = 0; bus.B_SEL = 0; bus.B_WDATA = 0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_we_n",  bus.RAM_WE_n, 1);
        check("rst_oe_n",  bus.RAM_OE_n, 1);
        check("rst_doe",   bus.RAM_DOE, 0);
        check("rst_ram_a", bus.RAM_A, 0);
        check("rst_ram_do", bus.RAM_DO, 0);
        check("rst_acks",  {bus.A_ACK, bus.B_ACK}, 0);
        check("rst_rdata", {bus.A_RDATA, bus.B_RDATA}, 0);

        // A: pointer 0x1234, write 0xA5, read pointer back
        op(0, 1, 2, 8'h34, 0, 4);
        op(0, 1, 3, 8'h12, 0, 4);
        op(0, 1, 0, 8'hA5, 0, 8);
        op(0, 0, 2, 0, 0, 4);
        op(0, 0, 3, 0, 0, 4);

        // B: same address, read back; A pointer untouched
        op(1, 1, 2, 8'h34, 0, 4);
        op(1, 1, 3, 8'h12, 0, 4);
        op(1, 0, 0, 0, 0, 8);
        op(1, 0, 2, 0, 0, 4);
        op(1, 0, 3, 0, 0, 4);
        op(0, 0, 2, 0, 0, 4);
        op(0, 0, 3, 0, 0, 4);

        // Simultaneous writes: last grant is B, so order must be A,B per round
        op(1, 1, 2, 8'h00, 0, 4);
        for (int r = 0; r < 4; r++) begin
            model_push(0, 1, 0, 8'h10 + 8'(r), 0);
            model_push(1, 1, 0, 8'h20 + 8'(r), 0);
            fork
                drive(0, 1, 0, 8'h10 + 8'(r), 0);
                drive(1, 1, 0, 8'h20 + 8'(r), 0);
            join
        end

        // Pointer wrap at the top of the address space
        op(0, 1, 2, 8'hFF, 0, 4);
        op(0, 1, 3, 8'hFF, 0, 4);
        op(0, 1, 0, 8'h77, 0, 8);
        op(0, 0, 2, 0, 0, 4);
        op(0, 0, 3, 0, 0, 4);

        // Randomised sequential traffic over a small address window
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 5);
            d = 8'($urandom);
            case (k)
                0: op(s, 1, 0, d, 0, 8);
                1: op(s, 0, 0, 0, 0, 8);
                2: op(s, 1, 2, d, 0, 4);
                3: op(s, 1, 3, 8'($urandom_range(0, 1)), 0, 4);
                4: op(s, 0, 2, 0, 0, 4);
                default: op(s, 0, 3, 0, 0, 4);
            endcase
        end

        // Reset during the second strobe cycle of a write
        op(0, 1, 2, 8'h10, 0, 4);
        op(0, 1, 3, 8'h20, 0, 4);
        op(1, 1, 2, 8'h55, 0, 4);
        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        bus.A_WR = 1; bus.A_SEL = 0; bus.A_WDATA = 8'h5A; bus.A_REQ = 1;
        repeat (5) @(posedge clk);
        #1;
        check("we_low_before_reset", bus.RAM_WE_n, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_we_n", bus.RAM_WE_n, 1);
        check("abort_doe",  bus.RAM_DOE, 0);
        check("abort_acks", {bus.A_ACK, bus.B_ACK}, 0);
        check("abort_ram_a", bus.RAM_A, 0);
        bus.A_REQ = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ptr_m[0] = '0;
        ptr_m[1] = '0;
        wr_q.delete();
        mon_en = 1'b1;
        op(0, 0, 2, 0, 0, 4);
        op(0, 0, 3, 0, 0, 4);
        op(1, 0, 2, 0, 0, 4);
        op(1, 0, 3, 0, 0, 4);

        // Status: A wins the tie while B waits -> pend_other=1, last_grant=A
        model_push(0, 0, 1, 0, 8'h02);
        model_push(1, 0, 2, 0, 0);
        fork
            drive(0, 0, 1, 0, 0);
            drive(1, 0, 2, 0, 0);
        join
        // Status from B, nothing else pending, B was last granted
        op(1, 0, 1, 0, 8'h01, 4);

        repeat (5) @(posedge clk);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        check("wr_q_drained",  wr_q.size(), 0);
        check("we_with_both_acks", both_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
